// File: rtl/dsp_mac_mc.sv
// rtl/dsp_mac_mc.sv - multi-channel saturating signed MAC slice with valid/ready streams
// Optional pre-adder (product = (in_d + in_b) * in_a) is enabled by defining DSP_PREADD_EN.
module dsp_mac_mc #(
    parameter int A_WIDTH   = 18,
    parameter int B_WIDTH   = 18,
    parameter int ACC_WIDTH = 48,
    parameter int N_CH      = 4,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   in_a,
    input  logic [B_WIDTH-1:0]   in_b,
    input  logic [B_WIDTH-1:0]   in_d,
    input  logic [CH_W-1:0]      in_ch,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic                 in_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_p,
    output logic [CH_W-1:0]      out_ch,
    output logic                 out_ovf
);
`ifdef DSP_PREADD_EN
    localparam int M_W = B_WIDTH + 1;
`else
    localparam int M_W = B_WIDTH;
`endif
    localparam int PROD_W = A_WIDTH + M_W;
    localparam int CH_MAX = 1 << CH_W;
    localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    logic signed [M_W-1:0] m_in;
`ifdef DSP_PREADD_EN
    assign m_in = M_W'(signed'(in_d)) + M_W'(signed'(in_b));
`else
    logic unused_d;
    assign unused_d = ^in_d;
    assign m_in     = in_b;
`endif

    logic                        s1_valid, s1_first, s1_last, s1_sub;
    logic signed [A_WIDTH-1:0]   s1_a;
    logic signed [M_W-1:0]       s1_m;
    logic [CH_W-1:0]             s1_ch;
    logic                        s2_valid, s2_first, s2_last, s2_sub;
    logic signed [PROD_W-1:0]    s2_prod;
    logic [CH_W-1:0]             s2_ch;
    logic                        s3_valid, s3_first, s3_last;
    logic signed [ACC_WIDTH:0]   s3_addend;
    logic [CH_W-1:0]             s3_ch;

    logic signed [ACC_WIDTH-1:0] acc [CH_MAX];
    logic [CH_MAX-1:0]           ovf;

    logic [CH_MAX-1:0]           ch_mask;
    logic                        s3_ch_ok, s3_ovf_now, s3_ovf_new;
    logic signed [ACC_WIDTH:0]   s3_base, s3_sum, s2_ext;
    logic [ACC_WIDTH-1:0]        s3_clamped;

    // Sum is one bit wider than the accumulator so overflow shows as a sign disagreement.
    always_comb begin
        for (int i = 0; i < CH_MAX; i++) ch_mask[i] = (i < N_CH);
        s2_ext     = (ACC_WIDTH+1)'(s2_prod);
        s3_ch_ok   = ch_mask[s3_ch];
        s3_base    = s3_first ? '0 : (ACC_WIDTH+1)'(acc[s3_ch]);
        s3_sum     = s3_base + s3_addend;
        s3_ovf_now = s3_sum[ACC_WIDTH] ^ s3_sum[ACC_WIDTH-1];
        if (!s3_ovf_now)
            s3_clamped = s3_sum[ACC_WIDTH-1:0];
        else if (s3_sum[ACC_WIDTH])
            s3_clamped = SAT_MIN;
        else
            s3_clamped = SAT_MAX;
        s3_ovf_new = (s3_first ? 1'b0 : ovf[s3_ch]) | s3_ovf_now;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid <= 1'b0; s1_first <= 1'b0; s1_last <= 1'b0; s1_sub <= 1'b0;
            s1_a     <= '0;   s1_m     <= '0;   s1_ch   <= '0;
            s2_valid <= 1'b0; s2_first <= 1'b0; s2_last <= 1'b0; s2_sub <= 1'b0;
            s2_prod  <= '0;   s2_ch    <= '0;
            s3_valid <= 1'b0; s3_first <= 1'b0; s3_last <= 1'b0;
            s3_addend <= '0;  s3_ch    <= '0;
            for (int i = 0; i < CH_MAX; i++) acc[i] <= '0;
            ovf       <= '0;
            out_valid <= 1'b0;
            out_p     <= '0;
            out_ch    <= '0;
            out_ovf   <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_a     <= in_a;
            s1_m     <= m_in;
            s1_ch    <= in_ch;
            s1_first <= in_first;
            s1_last  <= in_last;
            s1_sub   <= in_sub;

            s2_valid <= s1_valid;
            s2_prod  <= PROD_W'(s1_a) * PROD_W'(s1_m);
            s2_ch    <= s1_ch;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_sub   <= s1_sub;

            // Subtraction is folded into the addend so the accumulate stage is a plain add.
            s3_valid  <= s2_valid;
            s3_addend <= s2_sub ? -s2_ext : s2_ext;
            s3_ch     <= s2_ch;
            s3_first  <= s2_first;
            s3_last   <= s2_last;

            if (s3_valid && s3_ch_ok) begin
                acc[s3_ch] <= s3_clamped;
                ovf[s3_ch] <= s3_ovf_new;
            end

            if (s3_valid && s3_ch_ok && s3_last) begin
                out_valid <= 1'b1;
                out_p     <= s3_clamped;
                out_ch    <= s3_ch;
                out_ovf   <= s3_ovf_new;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dsp_mac_mc.sv
// tb/tb_dsp_mac_mc.sv - directed self-checking bench for dsp_mac_mc (48-bit and 36-bit accumulator builds)
module tb_dsp_mac_mc;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic        in_valid, in_first, in_last, in_sub, out_ready;
    logic [17:0] in_a, in_b, in_d;
    logic [1:0]  in_ch;

    logic        in_ready, out_valid, out_ovf;
    logic [47:0] out_p;
    logic [1:0]  out_ch;
    logic        in_ready36, out_valid36, out_ovf36;
    logic [35:0] out_p36;
    logic [1:0]  out_ch36;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic signed [63:0] p;
        logic [1:0]         ch;
        logic               ovf;
    } res_t;
    res_t q[$];
    res_t q36[$];

    always #5 CLK = ~CLK;

    dsp_mac_mc dut (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_d(in_d), .in_ch(in_ch),
        .in_first(in_first), .in_last(in_last), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .out_ch(out_ch), .out_ovf(out_ovf)
    );

    dsp_mac_mc #(.ACC_WIDTH(36)) dut36 (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready36),
        .in_a(in_a), .in_b(in_b), .in_d(in_d), .in_ch(in_ch),
        .in_first(in_first), .in_last(in_last), .in_sub(in_sub),
        .out_valid(out_valid36), .out_ready(out_ready), .out_p(out_p36),
        .out_ch(out_ch36), .out_ovf(out_ovf36)
    );

    always @(negedge CLK) begin
        res_t r;
        if (RST_N === 1'b1 && out_ready === 1'b1) begin
            if (out_valid === 1'b1) begin
                r.p = 64'($signed(out_p)); r.ch = out_ch; r.ovf = out_ovf;
                q.push_back(r);
            end
            if (out_valid36 === 1'b1) begin
                r.p = 64'($signed(out_p36)); r.ch = out_ch36; r.ovf = out_ovf36;
                q36.push_back(r);
            end
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int a, input int b, input int d, input int ch,
                        input bit first, input bit last, input bit sub);
        int guard;
        in_valid = 1'b1;
        in_a = 18'(a); in_b = 18'(b); in_d = 18'(d); in_ch = 2'(ch);
        in_first = first; in_last = last; in_sub = sub;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(posedge CLK); #1;
            guard++;
        end
        chk("send_in_ready", in_ready, 1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_res(input string tag, input bit use36, input logic signed [63:0] p,
                              input int ch, input bit ovf);
        int guard;
        res_t r;
        guard = 0;
        while ((use36 ? q36.size() : q.size()) == 0 && guard < 30) begin
            @(posedge CLK); #1;
            guard++;
        end
        chk({tag, "_present"}, ((use36 ? q36.size() : q.size()) > 0), 1);
        if ((use36 ? q36.size() : q.size()) > 0) begin
            r = use36 ? q36.pop_front() : q.pop_front();
            chk({tag, "_p"}, r.p, p);
            chk({tag, "_ch"}, r.ch, ch);
            chk({tag, "_ovf"}, r.ovf, ovf);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        RST_N = 1'b1;
        in_valid = 1'($urandom); in_a = 18'($urandom); in_b = 18'($urandom); in_d = 18'($urandom);
        in_ch = 2'($urandom); in_first = 1'($urandom); in_last = 1'($urandom); in_sub = 1'($urandom);
        out_ready = 1'($urandom);

        // asynchronous reset before any clock edge
        #3 RST_N = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_p", $signed(out_p), 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_out_valid36", out_valid36, 0);
        repeat (3) begin
            @(posedge CLK); #1;
            in_valid = 1'($urandom); in_a = 18'($urandom); in_b = 18'($urandom);
            in_last = 1'($urandom); out_ready = 1'($urandom);
        end
        chk("rst_hold_out_valid", out_valid, 0);
        RST_N = 1'b1;
        in_valid = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
        step(2);

        // single tap, latency 3
        send(3, -5, 0, 1, 1, 1, 0);
        chk("lat_k0", out_valid, 0);
        step(1); chk("lat_k1", out_valid, 0);
        step(1); chk("lat_k2", out_valid, 0);
        step(1); chk("lat_k3", out_valid, 1);
        chk("single_p", $signed(out_p), -15);
        chk("single_ch", out_ch, 1);
        chk("single_ovf", out_ovf, 0);
        expect_res("single", 0, -15, 1, 0);

        // interleaved channels
        send(2, 3, 0, 0, 1, 0, 0);
        send(-1, 7, 0, 2, 1, 0, 0);
        send(4, 5, 0, 0, 0, 1, 0);
        send(6, 6, 0, 2, 0, 1, 0);
        expect_res("ilv_ch0", 0, 26, 0, 0);
        expect_res("ilv_ch2", 0, 29, 2, 0);

        // back-to-back on one channel with subtract, then continuation without first
        send(1, 1, 0, 1, 1, 0, 0);
        send(2, 2, 0, 1, 0, 0, 0);
        send(3, 3, 0, 1, 0, 1, 1);
        send(5, 1, 0, 1, 0, 1, 0);
        expect_res("b2b_sub", 0, -4, 1, 0);
        expect_res("cont", 0, 1, 1, 0);

        // saturation: 36-bit build clamps, 48-bit build does not
        step(5);
        q.delete(); q36.delete();
        send(-131072, -131072, 0, 3, 1, 0, 0);
        send(-131072, -131072, 0, 3, 0, 0, 0);
        send(-131072, -131072, 0, 3, 0, 0, 0);
        send(-131072, -131072, 0, 3, 0, 1, 0);
        expect_res("sat48", 0, 64'sd68719476736, 3, 0);
        expect_res("sat36", 1, 64'sd34359738367, 3, 1);
        send(1, 1, 0, 3, 1, 1, 0);
        expect_res("clr48", 0, 1, 3, 0);
        expect_res("clr36", 1, 1, 3, 0);
        send(-131072, -131072, 0, 3, 1, 0, 1);
        send(-131072, -131072, 0, 3, 0, 0, 1);
        send(-131072, -131072, 0, 3, 0, 0, 1);
        send(-131072, -131072, 0, 3, 0, 1, 1);
        expect_res("nsat48", 0, -64'sd68719476736, 3, 0);
        expect_res("nsat36", 1, -64'sd34359738368, 3, 1);

        // backpressure
        step(3);
        out_ready = 1'b0;
        send(1, 2, 0, 0, 1, 1, 0);
        send(3, 4, 0, 1, 1, 1, 0);
        send(-2, 5, 0, 2, 1, 1, 0);
        step(1);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_p", $signed(out_p), 2);
        step(3);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_in_ready", in_ready, 0);
        chk("bp_hold_p", $signed(out_p), 2);
        chk("bp_hold_ch", out_ch, 0);
        chk("bp_none_taken", q.size(), 0);
        out_ready = 1'b1;
        expect_res("bp_r0", 0, 2, 0, 0);
        expect_res("bp_r1", 0, 12, 1, 0);
        expect_res("bp_r2", 0, -10, 2, 0);
        step(5);
        chk("bp_no_dup", q.size(), 0);

        // reset mid-flight discards the beat and clears accumulators
        send(10, 10, 0, 0, 1, 1, 0);
        #1 RST_N = 1'b0;
        #1 chk("midrst_out_valid", out_valid, 0);
        @(posedge CLK); #1 RST_N = 1'b1;
        step(5);
        chk("midrst_discard", q.size(), 0);
        send(2, 3, 0, 0, 0, 1, 0);
        expect_res("midrst_acc0", 0, 6, 0, 0);

        // pre-adder
        send(7, -4, 10, 2, 1, 1, 0);
`ifdef DSP_PREADD_EN
        expect_res("preadd", 0, 42, 2, 0);
`else
        expect_res("preadd", 0, -28, 2, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
